// File: rtl/checkpoint_table.sv
// Circular age-ordered branch checkpoint store: allocate at tail, retire in order at head,
// restore one cycle after a mispredict with younger-slot truncation; commit frees merge into live slots.
module checkpoint_table #(
  parameter int N_CKPT      = 4,
  parameter int N_ARCH_REGS = 32,
  parameter int N_PHYS_REGS = 64,
  parameter int PREG_W      = $clog2(N_PHYS_REGS),
  parameter int ROB_W       = 4,
  parameter int CK_W        = $clog2(N_CKPT)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          alloc_valid,
  output logic                          alloc_ready,
  output logic [CK_W-1:0]               alloc_id,
  input  logic [ROB_W-1:0]              alloc_rob_tag,
  input  logic [N_ARCH_REGS*PREG_W-1:0] alloc_rat,
  input  logic [N_PHYS_REGS-1:0]        alloc_freelist,
  input  logic                          res_valid,
  input  logic [CK_W-1:0]               res_id,
  input  logic                          res_mispredict,
  input  logic                          commit_free_valid,
  input  logic [PREG_W-1:0]             commit_free_preg,
  input  logic                          flush,
  output logic                          restore_valid,
  output logic [N_ARCH_REGS*PREG_W-1:0] restore_rat,
  output logic [N_PHYS_REGS-1:0]        restore_freelist,
  output logic [ROB_W-1:0]              restore_rob_tag,
  output logic [N_CKPT-1:0]             live_mask,
  output logic [CK_W:0]                 count
);
  localparam int RAT_W = N_ARCH_REGS * PREG_W;

  logic [CK_W-1:0]        r_head;
  logic [CK_W-1:0]        r_tail;
  logic [CK_W:0]          r_count;
  logic [N_CKPT-1:0]      r_valid;
  logic [N_CKPT-1:0]      r_done;
  logic [ROB_W-1:0]       r_rob_tag [N_CKPT];
  logic [RAT_W-1:0]       r_rat     [N_CKPT];
  logic [N_PHYS_REGS-1:0] r_fl      [N_CKPT];

  logic                   r_restore_valid;
  logic [RAT_W-1:0]       r_restore_rat;
  logic [N_PHYS_REGS-1:0] r_restore_fl;
  logic [ROB_W-1:0]       r_restore_tag;

  logic                   w_alloc;
  logic                   w_mispredict;
  logic                   w_resolve_ok;
  logic                   w_retire;
  logic [CK_W-1:0]        w_off_res;
  logic [N_CKPT-1:0]      w_kill;
  logic [N_PHYS_REGS-1:0] w_free_onehot;

  // Readiness looks only at the registered count, so a same-cycle retire never reopens a full table.
  assign alloc_ready  = (r_count < (CK_W+1)'(N_CKPT)) && !(res_valid && res_mispredict);
  assign alloc_id     = r_tail;
  assign w_alloc      = alloc_valid && alloc_ready && !flush;
  assign w_mispredict = res_valid && res_mispredict && r_valid[res_id];
  assign w_resolve_ok = res_valid && !res_mispredict && r_valid[res_id];
  assign w_retire     = (r_count != '0) && r_valid[r_head] && r_done[r_head] && !w_mispredict;
  assign w_off_res    = res_id - r_head;

  always_comb begin
    w_free_onehot = '0;
    if (commit_free_valid)
      w_free_onehot[commit_free_preg] = 1'b1;
  end

  // Kill every slot whose age (distance from head) is at least that of the mispredicted slot.
  always_comb begin
    w_kill = '0;
    for (int i = 0; i < N_CKPT; i++)
      w_kill[i] = (CK_W'(i) - r_head) >= w_off_res;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head          <= '0;
      r_tail          <= '0;
      r_count         <= '0;
      r_valid         <= '0;
      r_done          <= '0;
      r_restore_valid <= 1'b0;
      r_restore_rat   <= '0;
      r_restore_fl    <= '0;
      r_restore_tag   <= '0;
    end else if (flush) begin
      r_head          <= '0;
      r_tail          <= '0;
      r_count         <= '0;
      r_valid         <= '0;
      r_done          <= '0;
      r_restore_valid <= 1'b0;
    end else begin
      r_restore_valid <= w_mispredict;
      if (w_mispredict) begin
        r_restore_rat <= r_rat[res_id];
        r_restore_fl  <= r_fl[res_id] | w_free_onehot;
        r_restore_tag <= r_rob_tag[res_id];
        r_valid       <= r_valid & ~w_kill;
        r_tail        <= res_id;
        r_count       <= {1'b0, w_off_res};
      end else begin
        if (w_retire) begin
          r_valid[r_head] <= 1'b0;
          r_head          <= r_head + CK_W'(1);
        end
        if (w_resolve_ok)
          r_done[res_id] <= 1'b1;
        if (w_alloc) begin
          r_valid[r_tail] <= 1'b1;
          r_done[r_tail]  <= 1'b0;
          r_tail          <= r_tail + CK_W'(1);
        end
        r_count <= r_count + (CK_W+1)'(w_alloc) - (CK_W+1)'(w_retire);
      end
    end
  end

  // Snapshot payload needs no reset: it is only ever read from a valid slot.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CKPT; i++) begin
      if (w_alloc && (r_tail == CK_W'(i))) begin
        r_rob_tag[i] <= alloc_rob_tag;
        r_rat[i]     <= alloc_rat;
        r_fl[i]      <= alloc_freelist;
      end else if (r_valid[i]) begin
        r_fl[i] <= r_fl[i] | w_free_onehot;
      end
    end
  end

  assign restore_valid    = r_restore_valid;
  assign restore_rat      = r_restore_rat;
  assign restore_freelist = r_restore_fl;
  assign restore_rob_tag  = r_restore_tag;
  assign live_mask        = r_valid;
  assign count            = r_count;

endmodule

// File: tb/tb_checkpoint_table.sv
// Bench for checkpoint_table: queue-based reference model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic.
module tb_checkpoint_table;
  localparam int N     = 4;
  localparam int NA    = 32;
  localparam int NP    = 64;
  localparam int PW    = 6;
  localparam int RW    = 4;
  localparam int CW    = 2;
  localparam int RAT_W = NA * PW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic             alloc_valid;
  logic             alloc_ready;
  logic [CW-1:0]    alloc_id;
  logic [RW-1:0]    alloc_rob_tag;
  logic [RAT_W-1:0] alloc_rat;
  logic [NP-1:0]    alloc_freelist;
  logic             res_valid;
  logic [CW-1:0]    res_id;
  logic             res_mispredict;
  logic             commit_free_valid;
  logic [PW-1:0]    commit_free_preg;
  logic             flush;
  logic             restore_valid;
  logic [RAT_W-1:0] restore_rat;
  logic [NP-1:0]    restore_freelist;
  logic [RW-1:0]    restore_rob_tag;
  logic [N-1:0]     live_mask;
  logic [CW:0]      count;

  checkpoint_table #(
    .N_CKPT(N), .N_ARCH_REGS(NA), .N_PHYS_REGS(NP), .PREG_W(PW), .ROB_W(RW), .CK_W(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_id(alloc_id),
    .alloc_rob_tag(alloc_rob_tag), .alloc_rat(alloc_rat), .alloc_freelist(alloc_freelist),
    .res_valid(res_valid), .res_id(res_id), .res_mispredict(res_mispredict),
    .commit_free_valid(commit_free_valid), .commit_free_preg(commit_free_preg),
    .flush(flush),
    .restore_valid(restore_valid), .restore_rat(restore_rat),
    .restore_freelist(restore_freelist), .restore_rob_tag(restore_rob_tag),
    .live_mask(live_mask), .count(count)
  );

  typedef struct {
    int             id;
    logic [RW-1:0]  tag;
    logic [RAT_W-1:0] rat;
    logic [NP-1:0]  fl;
    bit             done;
  } ent_t;

  // Model: live checkpoints oldest-first, plus the head slot id and the held restore outputs.
  ent_t             q[$];
  int               head;
  logic             exp_rv;
  logic [RW-1:0]    exp_tag;
  logic [RAT_W-1:0] exp_rat;
  logic [NP-1:0]    exp_fl;

  int               n_chk;
  int               n_fail;
  logic [RAT_W-1:0] s_rat;
  logic [NP-1:0]    s_fl;
  logic [NP-1:0]    b20;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [N-1:0] m;
    m = '0;
    foreach (q[i]) m[q[i].id] = 1'b1;
    chk("alloc_ready", 256'(alloc_ready), 256'((q.size() < N) && !(res_valid && res_mispredict)));
    chk("alloc_id", 256'(alloc_id), 256'((head + q.size()) % N));
    chk("count", 256'(count), 256'(q.size()));
    chk("live_mask", 256'(live_mask), 256'(m));
    chk("restore_valid", 256'(restore_valid), 256'(exp_rv));
    chk("restore_rob_tag", 256'(restore_rob_tag), 256'(exp_tag));
    chk("restore_rat", 256'(restore_rat), 256'(exp_rat));
    chk("restore_freelist", 256'(restore_freelist), 256'(exp_fl));
  endtask

  task automatic model_step();
    int k;
    int new_id;
    bit misp, retire, do_alloc;
    ent_t e;
    logic [NP-1:0] oh;
    oh = '0;
    if (commit_free_valid) oh[commit_free_preg] = 1'b1;
    k = -1;
    foreach (q[i]) if (q[i].id == int'(res_id)) k = i;
    if (reset) begin
      q.delete(); head = 0; exp_rv = 1'b0;
      exp_tag = '0; exp_rat = '0; exp_fl = '0;
    end else if (flush) begin
      q.delete(); head = 0; exp_rv = 1'b0;
    end else begin
      misp   = res_valid && res_mispredict && (k >= 0);
      exp_rv = misp;
      if (misp) begin
        exp_tag = q[k].tag;
        exp_rat = q[k].rat;
        exp_fl  = q[k].fl | oh;
        while (q.size() > k) void'(q.pop_back());
        foreach (q[i]) begin e = q[i]; e.fl = e.fl | oh; q[i] = e; end
      end else begin
        do_alloc = alloc_valid && (q.size() < N) && !(res_valid && res_mispredict);
        new_id   = (head + q.size()) % N;
        retire   = (q.size() > 0) && q[0].done;
        if (res_valid && !res_mispredict && (k >= 0)) begin
          e = q[k]; e.done = 1'b1; q[k] = e;
        end
        foreach (q[i]) begin e = q[i]; e.fl = e.fl | oh; q[i] = e; end
        if (retire) begin
          void'(q.pop_front());
          head = (head + 1) % N;
        end
        if (do_alloc) begin
          e.id = new_id; e.tag = alloc_rob_tag; e.rat = alloc_rat;
          e.fl = alloc_freelist; e.done = 1'b0;
          q.push_back(e);
        end
      end
    end
  endtask

  task automatic cycle(input bit do_chk = 1'b1);
    #1;
    if (do_chk) check_model();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    reset = 1'b0; flush = 1'b0; alloc_valid = 1'b0; res_valid = 1'b0;
    res_mispredict = 1'b0; commit_free_valid = 1'b0; res_id = '0;
    commit_free_preg = '0;
  endtask

  task automatic rand_payload();
    for (int w = 0; w < RAT_W / 32; w++) alloc_rat[w*32 +: 32] = $urandom();
    alloc_freelist = {$urandom(), $urandom()};
  endtask

  task automatic fill(input int n, input int start);
    for (int i = 0; i < n; i++) begin
      alloc_valid = 1'b1;
      alloc_rob_tag = RW'(3 + 2 * i);
      rand_payload();
      if (i == 1) begin s_rat = alloc_rat; s_fl = alloc_freelist; end
      #1;
      chk("fill_alloc_id", 256'(alloc_id), 256'((start + i) % N));
      cycle();
    end
    idle();
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    b20 = '0; b20[20] = 1'b1;
    alloc_rob_tag = '0; alloc_rat = '0; alloc_freelist = '0;
    q.delete(); head = 0; exp_rv = 1'b0; exp_tag = '0; exp_rat = '0; exp_fl = '0;
    idle();
    reset = 1'b1;
    @(negedge clk);
    cycle(1'b0);
    cycle(1'b0);
    idle();
    #1;
    chk("rst_alloc_ready", 256'(alloc_ready), 256'(1));
    chk("rst_alloc_id", 256'(alloc_id), 256'(0));
    chk("rst_count", 256'(count), 256'(0));
    chk("rst_live_mask", 256'(live_mask), 256'(0));
    chk("rst_restore_valid", 256'(restore_valid), 256'(0));
    chk("rst_restore_fl", 256'(restore_freelist), 256'(0));

    // Fill all four slots with tags 3,5,7,9.
    fill(4, 0);
    #1;
    chk("full_count", 256'(count), 256'(4));
    chk("full_ready", 256'(alloc_ready), 256'(0));
    chk("full_live", 256'(live_mask), 256'(4'hF));

    // Out-of-order resolve: slot 1 then slot 0; retires follow on consecutive cycles.
    res_valid = 1'b1; res_id = 2'd1; cycle();
    res_id = 2'd0; cycle();
    idle(); cycle();
    #1;
    chk("retire1_count", 256'(count), 256'(3));
    chk("retire1_live", 256'(live_mask), 256'(4'b1110));
    cycle();
    #1;
    chk("retire2_count", 256'(count), 256'(2));
    chk("retire2_live", 256'(live_mask), 256'(4'b1100));

    flush = 1'b1; cycle(); idle();
    #1;
    chk("flush_count", 256'(count), 256'(0));
    chk("flush_alloc_id", 256'(alloc_id), 256'(0));
    fill(4, 0);

    // Mispredict on slot 1 truncates slots 1..3 and restores slot 1.
    res_valid = 1'b1; res_id = 2'd1; res_mispredict = 1'b1;
    #1;
    chk("misp_ready", 256'(alloc_ready), 256'(0));
    cycle(); idle();
    #1;
    chk("misp_rv", 256'(restore_valid), 256'(1));
    chk("misp_tag", 256'(restore_rob_tag), 256'(5));
    chk("misp_rat", 256'(restore_rat), 256'(s_rat));
    chk("misp_fl", 256'(restore_freelist), 256'(s_fl));
    chk("misp_live", 256'(live_mask), 256'(4'b0001));
    chk("misp_count", 256'(count), 256'(1));
    chk("misp_alloc_id", 256'(alloc_id), 256'(1));
    cycle();
    #1;
    chk("misp_pulse_end", 256'(restore_valid), 256'(0));
    chk("misp_tag_hold", 256'(restore_rob_tag), 256'(5));

    // Commit free merged into a live snapshot, then restored.
    flush = 1'b1; cycle(); idle();
    alloc_valid = 1'b1; alloc_rob_tag = 4'hA; rand_payload();
    alloc_freelist = alloc_freelist & ~b20; s_fl = alloc_freelist;
    cycle(); idle();
    commit_free_valid = 1'b1; commit_free_preg = 6'd20; cycle(); idle();
    res_valid = 1'b1; res_id = 2'd0; res_mispredict = 1'b1; cycle(); idle();
    #1;
    chk("merge_fl", 256'(restore_freelist), 256'(s_fl | b20));
    // Same-cycle commit free OR-ed into the restored free list.
    alloc_valid = 1'b1; alloc_rob_tag = 4'hB; rand_payload();
    alloc_freelist = alloc_freelist & ~b20; s_fl = alloc_freelist;
    cycle(); idle();
    res_valid = 1'b1; res_id = 2'd0; res_mispredict = 1'b1;
    commit_free_valid = 1'b1; commit_free_preg = 6'd20;
    cycle(); idle();
    #1;
    chk("merge_same_fl", 256'(restore_freelist), 256'(s_fl | b20));
    chk("merge_same_tag", 256'(restore_rob_tag), 256'(4'hB));

    // Allocation in a mispredict cycle is dropped.
    flush = 1'b1; cycle(); idle();
    fill(3, 0);
    res_valid = 1'b1; res_id = 2'd2; res_mispredict = 1'b1;
    alloc_valid = 1'b1; rand_payload();
    #1;
    chk("drop_ready", 256'(alloc_ready), 256'(0));
    cycle(); idle();
    #1;
    chk("drop_count", 256'(count), 256'(2));
    chk("drop_live", 256'(live_mask), 256'(4'b0011));
    chk("drop_next_id", 256'(alloc_id), 256'(2));
    alloc_valid = 1'b1; rand_payload(); cycle(); idle();
    #1;
    chk("drop_after_live", 256'(live_mask), 256'(4'b0111));

    // Reset alongside a mispredict cancels the restore.
    res_valid = 1'b1; res_id = 2'd0; res_mispredict = 1'b1; reset = 1'b1;
    cycle(); idle();
    #1;
    chk("rstmid_rv", 256'(restore_valid), 256'(0));
    chk("rstmid_tag", 256'(restore_rob_tag), 256'(0));
    chk("rstmid_count", 256'(count), 256'(0));

    // Wrap: six alloc/resolve/retire rounds leave head=tail=2, then fill to full and flush.
    for (int k = 0; k < 6; k++) begin
      alloc_valid = 1'b1; alloc_rob_tag = RW'(k); rand_payload(); cycle(); idle();
      res_valid = 1'b1; res_id = CW'(k % N); cycle(); idle();
      cycle();
    end
    #1;
    chk("wrap_count", 256'(count), 256'(0));
    chk("wrap_alloc_id", 256'(alloc_id), 256'(2));
    fill(4, 2);
    #1;
    chk("wrap_full_count", 256'(count), 256'(4));
    chk("wrap_full_ready", 256'(alloc_ready), 256'(0));
    chk("wrap_full_live", 256'(live_mask), 256'(4'hF));
    flush = 1'b1; cycle(); idle();
    #1;
    chk("wflush_count", 256'(count), 256'(0));
    chk("wflush_live", 256'(live_mask), 256'(0));
    chk("wflush_alloc_id", 256'(alloc_id), 256'(0));
    chk("wflush_rv", 256'(restore_valid), 256'(0));

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      reset             = ($urandom_range(0, 299) == 0);
      flush             = ($urandom_range(0, 79) == 0);
      alloc_valid       = ($urandom_range(0, 9) < 6);
      alloc_rob_tag     = RW'($urandom());
      rand_payload();
      res_valid         = ($urandom_range(0, 9) < 4);
      res_id            = CW'($urandom());
      res_mispredict    = ($urandom_range(0, 3) == 0);
      commit_free_valid = ($urandom_range(0, 1) == 1);
      commit_free_preg  = PW'($urandom());
      cycle();
    end
    idle();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/checkpoint_table.md
# checkpoint_table

Multi-slot branch checkpoint store for Phase 4 recovery, sitting between rename and the branch-resolution/recovery logic. It replaces per-ROB-tag snapshot storage with a parametrised circular table of N_CKPT age-ordered slots. Each slot holds the RAT map, the free list and the ROB tag captured after renaming a branch or jump. Slots retire in order, restore on mispredict with younger-slot truncation, and merge commit-time register frees into every live free-list snapshot so that a restore never leaks physical registers.

## Interface

**Parameters**
- N_CKPT, 4: number of slots; must be a power of two, ≥2.
- N_ARCH_REGS, 32: architectural registers.
- N_PHYS_REGS, 64: physical registers.
- PREG_W, $clog2(N_PHYS_REGS): physical tag width.
- ROB_W, 4: ROB tag width.
- CK_W, $clog2(N_CKPT): slot id width.

**Ports**
- clk  in  1  single clock; everything is on the rising edge.
- reset  in  1  synchronous, active-high.
- alloc_valid  in  1  rename requests a checkpoint this cycle.
- alloc_ready  out  1  asserted when count < N_CKPT and not mispredicting; combinational.
- alloc_id  out  CK_W  slot that is granted, equal to tail; combinational.
- alloc_rob_tag  in  ROB_W  ROB tag of the branch.
- alloc_rat  in  N_ARCH_REGS*PREG_W  RAT after renaming the branch.
- alloc_freelist  in  N_PHYS_REGS  free list after renaming the branch (1 = free).
- res_valid  in  1  a branch resolved.
- res_id  in  CK_W  slot of the resolved branch.
- res_mispredict  in  1  1 = mispredict (restore); 0 = correct.
- commit_free_valid  in  1  commit releases a physical register.
- commit_free_preg  in  PREG_W  the register being released.
- flush  in  1  full pipeline flush; discards all slots.
- restore_valid  out  1  one-cycle pulse carrying the restored snapshot.
- restore_rat  out  N_ARCH_REGS*PREG_W  restored RAT.
- restore_freelist  out  N_PHYS_REGS  restored free list.
- restore_rob_tag  out  ROB_W  ROB tag of the mispredicted branch.
- live_mask  out  N_CKPT  per-slot valid bits, used for branch-tag masking in the IQ.
- count  out  CK_W+1  number of live slots.

## Operation

**State**
- head and tail pointers, each CK_W bits, wrapping modulo N_CKPT.
- count.
- Per slot: valid, done, rob_tag, rat, freelist.

**Allocation** (alloc_valid && alloc_ready)
- Write the slot at tail with valid=1 and done=0.
- Advance tail by 1 and increment count.

**Resolve correct** (res_valid && !res_mispredict && valid[res_id])
- Set done[res_id].
- Resolves may arrive out of order.

**In-order retire**
- When count>0 and the head slot has valid && done: clear valid, advance head by 1, decrement count.
- At most one retire per cycle.

**Resolve mispredict** (res_valid && res_mispredict && valid[res_id])
- Register the slot's contents onto the restore_* outputs and pulse restore_valid.
- Clear valid for res_id and every younger slot, up to but not including the old tail.
- Set tail = res_id and count = (res_id − head) mod N_CKPT.
- Retire is suppressed in this cycle.

**Commit free merge**
- When commit_free_valid: set freelist[commit_free_preg] in every slot with valid=1.
- The bit is also OR-ed into restore_freelist when a mispredict occurs in the same cycle.

**Ignored events**
- A resolve to a slot with valid=0 is ignored, with no state change.

**Flush**
- Clear every valid and done bit; head = tail = 0; count = 0.
- No restore_valid pulse.

**Priority**: reset > flush > mispredict > {allocate, resolve-correct, retire, commit merge}.
- alloc_ready is forced to 0 while res_valid && res_mispredict, so an allocation in a mispredict cycle is dropped and the tail is not advanced.
- The allocate, resolve-correct, retire and commit-merge operations are mutually compatible and may all occur in one cycle. Count is updated by +alloc −retire.

**Reset values**
- head=0, tail=0, count=0, all valid and done bits 0, live_mask=0.
- restore_valid=0; restore_rat, restore_freelist and restore_rob_tag all 0.
- alloc_ready=1, alloc_id=0.

## Timing

- **Allocation**: slot contents and live_mask are visible on the edge following the request. alloc_id is valid in the request cycle.
- **Restore latency**: a mispredict presented in cycle t gives restore_valid=1 in t+1 only. Every restore_* output holds its value until the next restore.
- **Retire**: a resolve-correct of the head in cycle t sets done at the t edge. head advances at the t+1 edge, and count drops in t+2.
- **Full**: at count==N_CKPT, alloc_ready=0. A retire in the same cycle does not reopen alloc_ready; it is based on the registered count.
- **Wrap-around**: pointer arithmetic is modulo N_CKPT. count distinguishes full from empty when head==tail.
- **Reset mid-operation**: a pending restore is cancelled, and restore_valid is 0 in the following cycle.

## Test plan

1. Allocate 4 slots with tags 3,5,7,9 (N_CKPT=4) → alloc_id goes 0,1,2,3; count=4; alloc_ready=0; live_mask=4'b1111.
2. From state 1, resolve-correct slot 1, then slot 0 → head retires slot 0 then slot 1 on consecutive cycles; count goes 4→3→2; slots 2 and 3 stay live.
3. From state 1, mispredict on slot 1 → restore_valid pulses in the next cycle; restore_rob_tag=5 with slot 1's RAT and free list; live_mask=4'b0001; tail=1; count=1.
4. Allocate slot 0 with freelist bit 20 = 0, commit_free_preg=20, then mispredict on slot 0 → restore_freelist[20]=1.
5. Mispredict on slot 2 and alloc_valid in the same cycle → alloc_ready=0 and no allocation. The next allocation gets alloc_id=2.
6. Wrap plus flush: cycle 6 allocations and retirements so head=tail=2, then assert flush → count=0, live_mask=0, head=tail=0, and no restore_valid pulse.
